// File: rtl/checksum_arbiter_if.sv
// checksum_arbiter_if
// Bundles the request/operand/response wires between the checksum arbiter
// and the single shared checksum_gen instance.
//   master (arbiter side): drives cg_req_out and the operand fields,
//                          receives cg_gnt_in and cg_new_checksum_in.
//   slave  (checksum_gen side): the mirror image.
// Signals:
//   cg_req_out          - one-cycle request strobe to checksum_gen
//   cg_old_checksum_out - current IPv4 header checksum of the selected requester
//   cg_removed_val_out  - old DSCP value being replaced
//   cg_new_val_out      - replacement DSCP value
//   cg_dec_ttl_out      - TTL-decrement flag
//   cg_gnt_in           - checksum_gen completion strobe
//   cg_new_checksum_in  - updated checksum, valid with cg_gnt_in
interface checksum_arbiter_if;
  logic        cg_req_out;
  logic [15:0] cg_old_checksum_out;
  logic [5:0]  cg_removed_val_out;
  logic [5:0]  cg_new_val_out;
  logic        cg_dec_ttl_out;
  logic        cg_gnt_in;
  logic [15:0] cg_new_checksum_in;

  modport master (
    output cg_req_out, cg_old_checksum_out, cg_removed_val_out,
           cg_new_val_out, cg_dec_ttl_out,
    input  cg_gnt_in, cg_new_checksum_in
  );

  modport slave (
    input  cg_req_out, cg_old_checksum_out, cg_removed_val_out,
           cg_new_val_out, cg_dec_ttl_out,
    output cg_gnt_in, cg_new_checksum_in
  );
endinterface

// File: rtl/checksum_arbiter.sv
// checksum_arbiter
// Round-robin arbiter letting NUM_REQ header-creator requesters share one
// checksum_gen. A selected requester's operands are latched, issued to the
// checksum_gen for one cycle, and the result (or the original checksum on
// timeout) is returned together with a one-cycle gnt_out/err_out pulse.
// Ports:
//   CLK, reset        - single clock, synchronous active-high reset
//   req_in            - per-requester level request
//   old_checksum_in   - per-requester checksum, slice i = [16i+15:16i]
//   removed_dscp_in   - per-requester old DSCP, slice i = [6i+5:6i]
//   new_dscp_in       - per-requester new DSCP, slice i = [6i+5:6i]
//   dec_ttl_in        - per-requester TTL-decrement flag
//   gnt_out, err_out  - one-hot completion / timeout pulses
//   new_checksum_out  - result, valid in the gnt_out/err_out cycle, held after
//   busy_out          - high whenever the arbiter is not idle
//   cg                - master side of the checksum_gen link
module checksum_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_in,
  input  logic [NUM_REQ*16-1:0]  old_checksum_in,
  input  logic [NUM_REQ*6-1:0]   removed_dscp_in,
  input  logic [NUM_REQ*6-1:0]   new_dscp_in,
  input  logic [NUM_REQ-1:0]     dec_ttl_in,
  output logic [NUM_REQ-1:0]     gnt_out,
  output logic [NUM_REQ-1:0]     err_out,
  output logic [15:0]            new_checksum_out,
  output logic                   busy_out,
  checksum_arbiter_if.master     cg
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   sel;
  logic [CNT_W-1:0]   timeout_cnt;
  // One-hot of the requester answered last cycle; masks it for one IDLE cycle
  // so a requester still holding req_in while it sees its pulse is not re-served.
  logic [NUM_REQ-1:0] block_mask;

  logic [NUM_REQ-1:0] eligible;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [15:0]        pick_old;
  logic [5:0]         pick_removed;
  logic [5:0]         pick_new;
  logic               pick_dec_ttl;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [IDX_W-1:0]   next_ptr;
  logic               last_wait;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int offset);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + (IDX_W+1)'(offset);
    if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
    return sum[IDX_W-1:0];
  endfunction

  // First eligible requester at or after rr_ptr, plus its operand slices.
  always_comb begin
    eligible     = req_in & ~block_mask;
    pick_valid   = 1'b0;
    pick_idx     = '0;
    pick_old     = '0;
    pick_removed = '0;
    pick_new     = '0;
    pick_dec_ttl = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_valid && eligible[wrap_idx(rr_ptr, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(rr_ptr, k);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        pick_old     = old_checksum_in[16*i +: 16];
        pick_removed = removed_dscp_in[6*i +: 6];
        pick_new     = new_dscp_in[6*i +: 6];
        pick_dec_ttl = dec_ttl_in[i];
      end
    end
  end

  always_comb begin
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
    next_ptr        = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    // The count is about to reach TIMEOUT_CYCLES on this WAIT cycle.
    last_wait       = (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state                  <= ARB_IDLE;
      rr_ptr                 <= '0;
      sel                    <= '0;
      timeout_cnt            <= '0;
      block_mask             <= '0;
      gnt_out                <= '0;
      err_out                <= '0;
      new_checksum_out       <= '0;
      busy_out               <= 1'b0;
      cg.cg_req_out          <= 1'b0;
      cg.cg_old_checksum_out <= '0;
      cg.cg_removed_val_out  <= '0;
      cg.cg_new_val_out      <= '0;
      cg.cg_dec_ttl_out      <= 1'b0;
    end else begin
      gnt_out <= '0;
      err_out <= '0;
      case (state)
        ARB_IDLE: begin
          block_mask <= '0;
          if (pick_valid) begin
            sel                    <= pick_idx;
            cg.cg_old_checksum_out <= pick_old;
            cg.cg_removed_val_out  <= pick_removed;
            cg.cg_new_val_out      <= pick_new;
            cg.cg_dec_ttl_out      <= pick_dec_ttl;
            cg.cg_req_out          <= 1'b1;
            busy_out               <= 1'b1;
            state                  <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          cg.cg_req_out <= 1'b0;
          timeout_cnt   <= '0;
          state         <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // Completion is tested first so it wins a tie with the timeout.
          if (cg.cg_gnt_in) begin
            new_checksum_out <= cg.cg_new_checksum_in;
            gnt_out          <= sel_onehot;
            state            <= ARB_RESP;
          end else if (last_wait) begin
            new_checksum_out <= cg.cg_old_checksum_out;
            err_out          <= sel_onehot;
            state            <= ARB_RESP;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        ARB_RESP: begin
          rr_ptr     <= next_ptr;
          block_mask <= sel_onehot;
          busy_out   <= 1'b0;
          state      <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/checksum_arbiter.md
CHECKSUM_ARBITER -- requirements
Module: checksum_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of header-creator requesters sharing one checksum_gen.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum number of ARB_WAIT cycles before abort.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high.
REQ-005 SHALL have port req_in  input  NUM_REQ  per-requester checksum update request (level, held until gnt_out or err_out).
REQ-006 SHALL have port old_checksum_in  input  NUM_REQ*16  per-requester current IPv4 header checksum; slice i = [16i+15:16i].
REQ-007 SHALL have port removed_dscp_in  input  NUM_REQ*6  per-requester old DSCP.
REQ-008 SHALL have port new_dscp_in  input  NUM_REQ*6  per-requester replacement DSCP.
REQ-009 SHALL have port dec_ttl_in  input  NUM_REQ  per-requester TTL-decrement flag.
REQ-010 SHALL have port gnt_out  output  NUM_REQ  one-hot, one-cycle completion pulse.
REQ-011 SHALL have port err_out  output  NUM_REQ  one-hot, one-cycle timeout pulse.
REQ-012 SHALL have port new_checksum_out  output  16  result; valid in the gnt_out/err_out cycle.
REQ-013 SHALL have port busy_out  output  1  high whenever state != ARB_IDLE.
REQ-014 SHALL have ports cg_req_out (out 1), cg_old_checksum_out (out 16), cg_removed_val_out (out 6), cg_new_val_out (out 6), cg_dec_ttl_out (out 1): request and operands to the shared checksum_gen.
REQ-015 SHALL have ports cg_gnt_in (in 1) and cg_new_checksum_in (in 16): checksum_gen completion and result.

Function
REQ-016 SHALL implement states ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP; all outputs SHALL be registered.
REQ-017 ARB_IDLE: if any eligible req_in bit is set, SHALL select the first set bit at or after rr_ptr (wrapping NUM_REQ-1 -> 0), latch that requester's operands and index sel, and go to ARB_ISSUE; otherwise stay.
REQ-018 ARB_ISSUE: SHALL assert cg_req_out for exactly one cycle with the latched operands, clear the timeout counter, and go to ARB_WAIT.
REQ-019 cg_*_out operand ports SHALL hold the latched values from ARB_ISSUE through ARB_WAIT; cg_req_out SHALL be 0 in all other states.
REQ-020 ARB_WAIT: on cg_gnt_in=1, SHALL capture cg_new_checksum_in into new_checksum_out and go to ARB_RESP.
REQ-021 ARB_WAIT: the timeout counter SHALL increment each cycle; when it reaches TIMEOUT_CYCLES with cg_gnt_in=0, SHALL load new_checksum_out with the latched old checksum, flag error, and go to ARB_RESP.
REQ-022 If cg_gnt_in=1 in the same cycle the counter reaches TIMEOUT_CYCLES, completion SHALL win (no error).
REQ-023 ARB_RESP: SHALL pulse gnt_out[sel] (or err_out[sel] on timeout) for one cycle, set rr_ptr = (sel+1) mod NUM_REQ, and go to ARB_IDLE.
REQ-024 A requester's req_in bit SHALL be ineligible in the ARB_IDLE cycle immediately after its own gnt_out/err_out pulse.
REQ-025 Operands SHALL be latched only at selection; later changes or deassertion of req_in[sel] SHALL NOT cancel or alter the operation.
REQ-026 cg_gnt_in outside ARB_WAIT SHALL be ignored.
REQ-027 Latency: req_in[i] seen in ARB_IDLE at cycle T with cg_gnt_in in the first ARB_WAIT cycle SHALL give gnt_out[i] at T+3; the general case is completion cycle W giving gnt_out at W+1.
REQ-028 new_checksum_out SHALL hold its last value between responses.
REQ-029 At most one bit of gnt_out|err_out SHALL be set in any cycle.

Reset
REQ-030 reset=1 at any clock edge SHALL force ARB_IDLE, rr_ptr=0, timeout counter=0, and all outputs to 0, including mid-operation; an in-flight operation SHALL be dropped without gnt_out/err_out.
REQ-031 The first cycle after reset deassertion SHALL be a normal ARB_IDLE arbitration cycle.

Verification
REQ-032 Single request: req_in=4'b0100, old=16'hB1E6, removed=6'h00, new=6'h2E, dec_ttl=1, cg_gnt_in one cycle after cg_req_out with result 16'h1234 -> cg_* operands match, gnt_out=4'b0100 at T+3, new_checksum_out=16'h1234.
REQ-033 Fairness: req_in=4'b1111 held, with each requester dropping its request after its grant -> grant order 0,1,2,3, then repeat starting at 0.
REQ-034 Timeout: req_in[1] with old=16'hABCD and cg_gnt_in never asserted -> err_out=4'b0010 exactly TIMEOUT_CYCLES+1 cycles after cg_req_out, new_checksum_out=16'hABCD, gnt_out=0.
REQ-035 Tie: cg_gnt_in asserted in the cycle the counter hits TIMEOUT_CYCLES -> gnt_out pulses, err_out stays 0.
REQ-036 Reset in ARB_WAIT: reset asserted for one cycle during ARB_WAIT -> no gnt_out/err_out, busy_out=0, and the next request to requester 0 is granted first.
